dlx_instr_encoder: RTL and testbench
====================================

Name: dlx_instr_encoder

Overview:
- Encodes symbolic operation requests into 32-bit DLX instruction words, in the same format the control decoder consumes.
- Writes the words sequentially into instruction memory through a write port.
- Used as the program loader / self-test program generator ahead of the fetch stage.
- Bit numbering is big-endian [0:31], the same as the decoder: opcode [0:5], rs1 [6:10], rs2/rt [11:15], rd [16:20], func [26:31], imm16 [16:31], jump offset [6:31].

Parameters:
- AW, 8, instruction memory address width in words.
- BASE, 0, first write address after reset or clear.
- DEPTH, 256, number of writable words; last address is BASE+DEPTH-1 (BASE+DEPTH ≤ 2^AW).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- clear  in  1  synchronous; returns address to BASE, clears FULL and error flags.
- req_valid  in  1  request present.
- req_ready  out  1  encoder can accept this cycle.
- req_op  in  5  operation enum (see Decomposition).
- req_rs1  in  5  source register 1.
- req_rs2  in  5  source register 2 / I-type destination.
- req_rd  in  5  R-type destination.
- req_imm  in  26  immediate or jump offset, two's complement.
- imem_we  out  1  write strobe, one cycle per word.
- imem_addr  out  AW  write address.
- imem_wdata  out  [0:31]  encoded instruction.
- words_written  out  AW+1  count of words written since reset or clear.
- full  out  1  DEPTH words written.
- err_illegal  out  1  sticky; set by an unknown op or an out-of-range immediate.

Behaviour:
- Reset values: req_ready=1, imem_we=0, imem_addr=BASE, imem_wdata=0, words_written=0, full=0, err_illegal=0, state=IDLE.
- The state machine has three states: IDLE, WRITE, FULL.
- IDLE:
  - req_ready=1. A handshake is req_valid&req_ready at a rising edge.
  - On handshake with a legal request, register the encoded word and go to WRITE.
  - On handshake with an illegal request, set err_illegal, write nothing, stay in IDLE.
- WRITE:
  - imem_we=1 for exactly one cycle, with imem_addr and imem_wdata stable; req_ready=0.
  - At the end of the cycle, words_written is incremented.
  - If imem_addr is BASE+DEPTH-1, go to FULL and hold imem_addr. Otherwise increment imem_addr and return to IDLE.
- FULL: req_ready=0, full=1, no writes. Requests are held off, not dropped.
- Latency and throughput:
  - Handshake at edge N puts imem_we high during cycle N+1.
  - Throughput is one word per 2 cycles.
- clear is checked ahead of the state logic in any state. It forces IDLE, imem_addr=BASE, words_written=0, full=0, err_illegal=0.
  - A handshake in the same cycle as clear is ignored.
  - A write in flight when clear is asserted completes on the bus in that cycle, but it is not counted.
- imem_we is low whenever the state is not WRITE.
- Encoding rules:
  - R-type (ADD/ADDU/SUB/SUBU/AND/OR/XOR): opcode 000000; func 100000/100001/100010/100011/100100/100101/100110; rs1, rs2 and rd fields taken from the request; bits [21:25]=0.
  - FP: MULT uses opcode 000001, func 001110. MOVFP2I uses opcode 000000, func 110100. MOVI2FP uses opcode 000000, func 110101.
  - I-type ALU: ADDI 001000, ADDUI 001001, SUBI 001010, SUBUI 001011, ANDI 001100, ORI 001101, XORI 001110. Fields are rs1 at [6:10], rs2 as destination at [11:15], imm[15:0] at [16:31].
  - LW 100011 and SW 101011 use the same field layout as I-type ALU.
  - BEQZ 000100 and BNEZ 000101: rs1 at [6:10], [11:15]=0, imm16 at [16:31].
  - J 000010 and JAL 000011: imm[25:0] at [6:31].
  - NOP encodes as 32'h00000000.
- Range check, which makes the request illegal (no write):
  - Signed 16-bit ops (ADDI, SUBI, ANDI, ORI, XORI, LW, SW, BEQZ, BNEZ) require req_imm[25:16] to equal a sign-extension of req_imm[15].
  - ADDUI and SUBUI require req_imm[25:16]=0.
  - J and JAL are always in range.
  - Unused enum values are illegal.
- Register fields not used by an op are forced to 0 regardless of input.

Decomposition:
- Package dlx_isa_pkg holds:
  - the op enum (NOP, ADD, ADDU, SUB, SUBU, AND, OR, XOR, ADDI, ADDUI, SUBI, SUBUI, ANDI, ORI, XORI, LW, SW, BEQZ, BNEZ, J, JAL, MULT, MOVFP2I, MOVI2FP);
  - 6-bit opcode and func constants;
  - field position constants.
- The decoder reuses the same package.
- One sub-module, dlx_encode_word: purely combinational map from op/fields to {word, legal}.
- The top level holds the state machine, address counter and flags.

Test Plan:
- ADD rs1=1 rs2=2 rd=3 after reset → imem_we one cycle later at addr 0, wdata 32'h00221820; words_written=1.
- ADDI rs1=4 rs2=5 imm=-1 (26'h3FFFFFF) → wdata 32'h2085FFFF. The same request with ADDUI → no write, err_illegal=1, req_ready stays 1.
- J imm=26'h0000010 then SW rs1=2 rs2=7 imm=8 → addr 0 gets 32'h08000010, addr 1 gets 32'hAC470008.
- DEPTH=4: five back-to-back requests with req_valid held high → four writes at addr 0..3, full=1, req_ready=0, fifth request still pending; clear → fifth is written at addr 0.
- Assert rst during WRITE → imem_we drops immediately (asynchronous), all outputs return to reset values; clear asserted in the handshake cycle → no write, counters zero.
- Unused enum value → err_illegal set and sticky across later legal writes until clear.

Source files
------------

// File: rtl/dlx_isa_pkg.sv
// DLX ISA definitions shared by the instruction encoder and the control decoder.
// Instruction bits are numbered big-endian [0:31]; bit 0 is the MSB.
package dlx_isa_pkg;

  // Symbolic operation requests; codes 24..31 are unused and rejected.
  typedef enum logic [4:0] {
    OP_NOP     = 5'd0,
    OP_ADD     = 5'd1,
    OP_ADDU    = 5'd2,
    OP_SUB     = 5'd3,
    OP_SUBU    = 5'd4,
    OP_AND     = 5'd5,
    OP_OR      = 5'd6,
    OP_XOR     = 5'd7,
    OP_ADDI    = 5'd8,
    OP_ADDUI   = 5'd9,
    OP_SUBI    = 5'd10,
    OP_SUBUI   = 5'd11,
    OP_ANDI    = 5'd12,
    OP_ORI     = 5'd13,
    OP_XORI    = 5'd14,
    OP_LW      = 5'd15,
    OP_SW      = 5'd16,
    OP_BEQZ    = 5'd17,
    OP_BNEZ    = 5'd18,
    OP_J       = 5'd19,
    OP_JAL     = 5'd20,
    OP_MULT    = 5'd21,
    OP_MOVFP2I = 5'd22,
    OP_MOVI2FP = 5'd23
  } dlx_op_e;

  // Encoder sequencing states.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_FULL  = 2'd2
  } enc_state_e;

  // Primary opcodes.
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_FPU   = 6'b000001;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_BEQZ  = 6'b000100;
  localparam logic [5:0] OPC_BNEZ  = 6'b000101;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDUI = 6'b001001;
  localparam logic [5:0] OPC_SUBI  = 6'b001010;
  localparam logic [5:0] OPC_SUBUI = 6'b001011;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_XORI  = 6'b001110;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  // Function codes for R-type and FP words.
  localparam logic [5:0] FN_ADD     = 6'b100000;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [5:0] FN_SUB     = 6'b100010;
  localparam logic [5:0] FN_SUBU    = 6'b100011;
  localparam logic [5:0] FN_AND     = 6'b100100;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_XOR     = 6'b100110;
  localparam logic [5:0] FN_MULT    = 6'b001110;
  localparam logic [5:0] FN_MOVFP2I = 6'b110100;
  localparam logic [5:0] FN_MOVI2FP = 6'b110101;

  // Field positions (left index is the more significant bit).
  localparam int F_OPC_L  = 0;
  localparam int F_OPC_R  = 5;
  localparam int F_RS1_L  = 6;
  localparam int F_RS1_R  = 10;
  localparam int F_RS2_L  = 11;
  localparam int F_RS2_R  = 15;
  localparam int F_RD_L   = 16;
  localparam int F_RD_R   = 20;
  localparam int F_FN_L   = 26;
  localparam int F_FN_R   = 31;
  localparam int F_IMM_L  = 16;
  localparam int F_IMM_R  = 31;
  localparam int F_JOFF_L = 6;
  localparam int F_JOFF_R = 31;

  // R-type layout: opcode, rs1, rs2, rd, five zero bits, func.
  function automatic logic [0:31] enc_r(input logic [5:0] opc, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [4:0] rd,
                                        input logic [5:0] fn);
    logic [0:31] w;
    w = 32'h0000_0000;
    w[F_OPC_L:F_OPC_R] = opc;
    w[F_RS1_L:F_RS1_R] = rs1;
    w[F_RS2_L:F_RS2_R] = rs2;
    w[F_RD_L:F_RD_R]   = rd;
    w[F_FN_L:F_FN_R]   = fn;
    return w;
  endfunction

  // I-type layout: opcode, rs1, rs2 (destination or zero), imm16.
  function automatic logic [0:31] enc_i(input logic [5:0] opc, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [15:0] imm);
    logic [0:31] w;
    w = 32'h0000_0000;
    w[F_OPC_L:F_OPC_R] = opc;
    w[F_RS1_L:F_RS1_R] = rs1;
    w[F_RS2_L:F_RS2_R] = rs2;
    w[F_IMM_L:F_IMM_R] = imm;
    return w;
  endfunction

  // J-type layout: opcode followed by the 26-bit offset.
  function automatic logic [0:31] enc_j(input logic [5:0] opc, input logic [25:0] off);
    logic [0:31] w;
    w = 32'h0000_0000;
    w[F_OPC_L:F_OPC_R]   = opc;
    w[F_JOFF_L:F_JOFF_R] = off;
    return w;
  endfunction

  // The upper ten bits must be copies of bit 15 for a signed 16-bit immediate.
  function automatic logic fits_s16(input logic [25:0] imm);
    return (imm[25:16] == {10{imm[15]}});
  endfunction

  // The upper ten bits must be clear for an unsigned 16-bit immediate.
  function automatic logic fits_u16(input logic [25:0] imm);
    return (imm[25:16] == 10'd0);
  endfunction

endpackage

// File: rtl/dlx_instr_encoder_if.sv
// Request handshake and instruction-memory write bus of the DLX encoder.
interface dlx_instr_encoder_if #(parameter int AW = 8);
  logic          req_valid;
  logic          req_ready;
  logic [4:0]    req_op;
  logic [4:0]    req_rs1;
  logic [4:0]    req_rs2;
  logic [4:0]    req_rd;
  logic [25:0]   req_imm;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [0:31]   imem_wdata;

  // Requester / memory side.
  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_rd, req_imm,
    input  req_ready, imem_we, imem_addr, imem_wdata
  );

  // Encoder side.
  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_rd, req_imm,
    output req_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/dlx_encode_word.sv
// Combinational map from a symbolic request to a DLX word plus a legality flag.
// Register fields an op does not use are forced to zero.
import dlx_isa_pkg::*;

module dlx_encode_word (
  input  logic [4:0]  i_op,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  input  logic [4:0]  i_rd,
  input  logic [25:0] i_imm,
  output logic [0:31] o_word,
  output logic        o_legal
);

  logic [0:31] w_word;
  logic        w_legal;
  logic        w_s16;
  logic        w_u16;

  assign w_s16 = fits_s16(i_imm);
  assign w_u16 = fits_u16(i_imm);

  // Select the word layout and range rule for the requested op.
  always_comb begin
    w_word  = 32'h0000_0000;
    w_legal = 1'b0;
    case (i_op)
      OP_NOP:     begin w_word = 32'h0000_0000;                                      w_legal = 1'b1;  end
      OP_ADD:     begin w_word = enc_r(OPC_RTYPE, i_rs1, i_rs2, i_rd, FN_ADD);       w_legal = 1'b1;  end
      OP_ADDU:    begin w_word = enc_r(OPC_RTYPE, i_rs1, i_rs2, i_rd, FN_ADDU);      w_legal = 1'b1;  end
      OP_SUB:     begin w_word = enc_r(OPC_RTYPE, i_rs1, i_rs2, i_rd, FN_SUB);       w_legal = 1'b1;  end
      OP_SUBU:    begin w_word = enc_r(OPC_RTYPE, i_rs1, i_rs2, i_rd, FN_SUBU);      w_legal = 1'b1;  end
      OP_AND:     begin w_word = enc_r(OPC_RTYPE, i_rs1, i_rs2, i_rd, FN_AND);       w_legal = 1'b1;  end
      OP_OR:      begin w_word = enc_r(OPC_RTYPE, i_rs1, i_rs2, i_rd, FN_OR);        w_legal = 1'b1;  end
      OP_XOR:     begin w_word = enc_r(OPC_RTYPE, i_rs1, i_rs2, i_rd, FN_XOR);       w_legal = 1'b1;  end
      OP_MULT:    begin w_word = enc_r(OPC_FPU,   i_rs1, i_rs2, i_rd, FN_MULT);      w_legal = 1'b1;  end
      OP_MOVFP2I: begin w_word = enc_r(OPC_RTYPE, i_rs1, i_rs2, i_rd, FN_MOVFP2I);   w_legal = 1'b1;  end
      OP_MOVI2FP: begin w_word = enc_r(OPC_RTYPE, i_rs1, i_rs2, i_rd, FN_MOVI2FP);   w_legal = 1'b1;  end
      OP_ADDI:    begin w_word = enc_i(OPC_ADDI,  i_rs1, i_rs2, i_imm[15:0]);        w_legal = w_s16; end
      OP_ADDUI:   begin w_word = enc_i(OPC_ADDUI, i_rs1, i_rs2, i_imm[15:0]);        w_legal = w_u16; end
      OP_SUBI:    begin w_word = enc_i(OPC_SUBI,  i_rs1, i_rs2, i_imm[15:0]);        w_legal = w_s16; end
      OP_SUBUI:   begin w_word = enc_i(OPC_SUBUI, i_rs1, i_rs2, i_imm[15:0]);        w_legal = w_u16; end
      OP_ANDI:    begin w_word = enc_i(OPC_ANDI,  i_rs1, i_rs2, i_imm[15:0]);        w_legal = w_s16; end
      OP_ORI:     begin w_word = enc_i(OPC_ORI,   i_rs1, i_rs2, i_imm[15:0]);        w_legal = w_s16; end
      OP_XORI:    begin w_word = enc_i(OPC_XORI,  i_rs1, i_rs2, i_imm[15:0]);        w_legal = w_s16; end
      OP_LW:      begin w_word = enc_i(OPC_LW,    i_rs1, i_rs2, i_imm[15:0]);        w_legal = w_s16; end
      OP_SW:      begin w_word = enc_i(OPC_SW,    i_rs1, i_rs2, i_imm[15:0]);        w_legal = w_s16; end
      OP_BEQZ:    begin w_word = enc_i(OPC_BEQZ,  i_rs1, 5'd0,  i_imm[15:0]);        w_legal = w_s16; end
      OP_BNEZ:    begin w_word = enc_i(OPC_BNEZ,  i_rs1, 5'd0,  i_imm[15:0]);        w_legal = w_s16; end
      OP_J:       begin w_word = enc_j(OPC_J,   i_imm);                              w_legal = 1'b1;  end
      OP_JAL:     begin w_word = enc_j(OPC_JAL, i_imm);                              w_legal = 1'b1;  end
      default:    begin w_word = 32'h0000_0000;                                      w_legal = 1'b0;  end
    endcase
  end

  assign o_word  = w_word;
  assign o_legal = w_legal;

endmodule

// File: rtl/dlx_instr_encoder.sv
// DLX program loader: accepts symbolic requests, encodes them and writes the
// words to sequential instruction-memory addresses, one word every two cycles.
import dlx_isa_pkg::*;

module dlx_instr_encoder #(
  parameter int AW    = 8,
  parameter int BASE  = 0,
  parameter int DEPTH = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  dlx_instr_encoder_if.slave   bus,
  output logic [AW:0]          words_written,
  output logic                 full,
  output logic                 err_illegal
);

  localparam logic [AW-1:0] ADDR_BASE = AW'(BASE);
  localparam logic [AW-1:0] ADDR_LAST = AW'(BASE + DEPTH - 1);

  enc_state_e    r_state;
  enc_state_e    w_next;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_addr_nxt;
  logic [0:31]   r_wdata;
  logic [0:31]   w_wdata_nxt;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_nxt;
  logic          r_err;
  logic          w_err_nxt;
  logic          r_we;
  logic          r_ready;
  logic          r_full;
  logic [0:31]   w_word;
  logic          w_legal;
  logic          w_hs;

  dlx_encode_word u_encode (
    .i_op    (bus.req_op),
    .i_rs1   (bus.req_rs1),
    .i_rs2   (bus.req_rs2),
    .i_rd    (bus.req_rd),
    .i_imm   (bus.req_imm),
    .o_word  (w_word),
    .o_legal (w_legal)
  );

  // r_ready is high only in IDLE, so a handshake can only be taken there.
  assign w_hs = bus.req_valid & r_ready;

  // Next state and datapath updates; clear overrides everything else.
  always_comb begin
    w_next      = r_state;
    w_addr_nxt  = r_addr;
    w_wdata_nxt = r_wdata;
    w_count_nxt = r_count;
    w_err_nxt   = r_err;
    if (clear) begin
      w_next      = S_IDLE;
      w_addr_nxt  = ADDR_BASE;
      w_count_nxt = '0;
      w_err_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs && w_legal) begin
            w_wdata_nxt = w_word;
            w_next      = S_WRITE;
          end else if (w_hs) begin
            w_err_nxt = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
        S_WRITE: begin
          w_count_nxt = r_count + (AW+1)'(1);
          if (r_addr == ADDR_LAST) begin
            w_next = S_FULL;
          end else begin
            w_addr_nxt = r_addr + AW'(1);
            w_next     = S_IDLE;
          end
        end
        S_FULL: begin
          w_next = S_FULL;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

  // State, datapath and registered output strobes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_addr  <= ADDR_BASE;
      r_wdata <= 32'h0000_0000;
      r_count <= '0;
      r_err   <= 1'b0;
      r_we    <= 1'b0;
      r_ready <= 1'b1;
      r_full  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_addr  <= w_addr_nxt;
      r_wdata <= w_wdata_nxt;
      r_count <= w_count_nxt;
      r_err   <= w_err_nxt;
      r_we    <= (w_next == S_WRITE);
      r_ready <= (w_next == S_IDLE);
      r_full  <= (w_next == S_FULL);
    end
  end

  assign bus.req_ready  = r_ready;
  assign bus.imem_we    = r_we;
  assign bus.imem_addr  = r_addr;
  assign bus.imem_wdata = r_wdata;
  assign words_written  = r_count;
  assign full           = r_full;
  assign err_illegal    = r_err;

endmodule

// File: tb/tb_dlx_instr_encoder.sv
// Scoreboard bench for dlx_instr_encoder (DEPTH=4 so the FULL path is reachable).
`timescale 1ns/1ps
module tb_dlx_instr_encoder;
  import dlx_isa_pkg::*;

  localparam int AW    = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [7:0]  a;
    logic [31:0] d;
  } exp_t;

  logic clk;
  logic rst;
  logic clear;
  logic [AW:0] words_written;
  logic full;
  logic err_illegal;

  dlx_instr_encoder_if #(.AW(AW)) bus ();

  dlx_instr_encoder #(.AW(AW), .BASE(0), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .clear         (clear),
    .bus           (bus),
    .words_written (words_written),
    .full          (full),
    .err_illegal   (err_illegal)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  int   m_addr  = 0;
  int   m_count = 0;
  bit   m_err   = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory-side monitor: every write strobe must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_val("unexpected_write", 32'(bus.imem_addr), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("wr_addr", 32'(bus.imem_addr), 32'(e.a));
        check_val("wr_data", bus.imem_wdata, e.d);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [25:0] imm);
    bus.req_op    = op;
    bus.req_rs1   = rs1;
    bus.req_rs2   = rs2;
    bus.req_rd    = rd;
    bus.req_imm   = imm;
    bus.req_valid = 1'b1;
  endtask

  // Wait (bounded) for ready, record expectations, then step to the cycle after the handshake.
  task automatic wait_hs(input bit legal, input logic [31:0] exp_word);
    int n;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_val("hs_ready", 32'(bus.req_ready), 32'd1);
    if (legal) begin
      exp_q.push_back('{a: 8'(m_addr), d: exp_word});
      m_count++;
      if (m_addr != DEPTH - 1) m_addr++;
    end else begin
      m_err = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check_val(legal ? "we_latency" : "illegal_no_we", 32'(bus.imem_we), legal ? 32'd1 : 32'd0);
  endtask

  task automatic send(input logic [4:0] op, input logic [4:0] rs1, input logic [4:0] rs2,
                      input logic [4:0] rd, input logic [25:0] imm, input bit legal,
                      input logic [31:0] exp_word);
    set_req(op, rs1, rs2, rd, imm);
    wait_hs(legal, exp_word);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_addr  = 0;
    m_count = 0;
    m_err   = 1'b0;
    check_val("clr_count", 32'(words_written), 32'd0);
    check_val("clr_addr",  32'(bus.imem_addr), 32'd0);
    check_val("clr_err",   32'(err_illegal), 32'd0);
    check_val("clr_full",  32'(full), 32'd0);
  endtask

  task automatic check_flags(input string tag);
    check_val({tag, "_count"}, 32'(words_written), 32'(m_count));
    check_val({tag, "_err"},   32'(err_illegal), 32'(m_err));
  endtask

  initial begin
    rst = 1'b1;
    clear = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = 5'd0; bus.req_rs1 = 5'd0; bus.req_rs2 = 5'd0; bus.req_rd = 5'd0;
    bus.req_imm = 26'd0;
    @(negedge clk);
    @(negedge clk);
    check_val("rst_ready", 32'(bus.req_ready), 32'd1);
    check_val("rst_we",    32'(bus.imem_we), 32'd0);
    check_val("rst_addr",  32'(bus.imem_addr), 32'd0);
    check_val("rst_wdata", bus.imem_wdata, 32'h0);
    check_val("rst_count", 32'(words_written), 32'd0);
    check_val("rst_full",  32'(full), 32'd0);
    check_val("rst_err",   32'(err_illegal), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // ADD, ADDI legal, ADDUI out of range.
    send(OP_ADD, 5'd1, 5'd2, 5'd3, 26'd0, 1'b1, 32'h0022_1820);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_flags("add");
    send(OP_ADDI, 5'd4, 5'd5, 5'd0, 26'h3FF_FFFF, 1'b1, 32'h2085_FFFF);
    bus.req_valid = 1'b0;
    @(negedge clk);
    send(OP_ADDUI, 5'd4, 5'd5, 5'd0, 26'h3FF_FFFF, 1'b0, 32'h0);
    bus.req_valid = 1'b0;
    check_val("addui_err", 32'(err_illegal), 32'd1);
    check_val("addui_ready", 32'(bus.req_ready), 32'd1);
    check_flags("addui");
    do_clear();

    // J, SW, BEQZ (rs2 forced 0), LW fill all four words.
    send(OP_J,    5'd9,  5'd9, 5'd9, 26'h000_0010, 1'b1, 32'h0800_0010);
    send(OP_SW,   5'd2,  5'd7, 5'd9, 26'h000_0008, 1'b1, 32'hAC47_0008);
    send(OP_BEQZ, 5'd3,  5'd9, 5'd9, 26'h3FF_FFFC, 1'b1, 32'h1060_FFFC);
    send(OP_ADDI, 5'd1,  5'd1, 5'd0, 26'h001_0000, 1'b0, 32'h0);
    send(OP_LW,   5'd31, 5'd1, 5'd9, 26'h3FF_8000, 1'b1, 32'h8FE1_8000);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_val("fill_full", 32'(full), 32'd1);
    check_val("fill_ready", 32'(bus.req_ready), 32'd0);
    check_flags("fill");
    do_clear();

    // Five back-to-back requests with valid held high.
    send(OP_MULT,  5'd1, 5'd2, 5'd3, 26'd0,        1'b1, 32'h0422_180E);
    send(OP_NOP,   5'd7, 5'd7, 5'd7, 26'h3FF_FFFF, 1'b1, 32'h0000_0000);
    send(OP_SUBUI, 5'd0, 5'd0, 5'd5, 26'h000_FFFF, 1'b1, 32'h2C00_FFFF);
    send(OP_ADD,   5'd1, 5'd2, 5'd3, 26'd0,        1'b1, 32'h0022_1820);
    set_req(OP_XOR, 5'd7, 5'd8, 5'd9, 26'd0);
    repeat (4) @(negedge clk);
    check_val("b2b_full",  32'(full), 32'd1);
    check_val("b2b_ready", 32'(bus.req_ready), 32'd0);
    check_val("b2b_we",    32'(bus.imem_we), 32'd0);
    check_val("b2b_addr",  32'(bus.imem_addr), 32'd3);
    check_flags("b2b");
    do_clear();
    wait_hs(1'b1, 32'h00E8_4826);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_flags("after_clr");

    // Clear while a write is on the bus: write completes but is not counted.
    do_clear();
    send(OP_OR, 5'd1, 5'd1, 5'd1, 26'd0, 1'b1, 32'h0021_0825);
    bus.req_valid = 1'b0;
    do_clear();

    // Asynchronous reset in the middle of a write.
    send(OP_SUB, 5'd2, 5'd3, 5'd4, 26'd0, 1'b1, 32'h0043_2022);
    bus.req_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_val("arst_we",    32'(bus.imem_we), 32'd0);
    check_val("arst_ready", 32'(bus.req_ready), 32'd1);
    check_val("arst_addr",  32'(bus.imem_addr), 32'd0);
    check_val("arst_wdata", bus.imem_wdata, 32'h0);
    check_val("arst_count", 32'(words_written), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_addr = 0; m_count = 0; m_err = 1'b0;
    @(negedge clk);

    // Handshake coinciding with clear is ignored.
    set_req(OP_ADD, 5'd1, 5'd2, 5'd3, 26'd0);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    bus.req_valid = 1'b0;
    check_val("clrhs_we", 32'(bus.imem_we), 32'd0);
    @(negedge clk);
    check_val("clrhs_we2", 32'(bus.imem_we), 32'd0);
    check_flags("clrhs");

    // Unused op code: sticky error across a later legal write.
    send(5'd30, 5'd1, 5'd2, 5'd3, 26'd0, 1'b0, 32'h0);
    bus.req_valid = 1'b0;
    check_val("unused_err", 32'(err_illegal), 32'd1);
    send(OP_BNEZ, 5'd6, 5'd6, 5'd6, 26'h000_0004, 1'b1, 32'h14C0_0004);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_val("sticky_err", 32'(err_illegal), 32'd1);
    check_flags("sticky");
    do_clear();

    repeat (3) @(negedge clk);
    check_val("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
